rv_instr_encoder: RTL and testbench

//  Inverse of the instruction decoder: packs RISC-V RV32I fields (format, opcode, rd, rs1, rs2,

---
 rtl/rv_pkg.sv | 48 ++++
 rtl/rv_imm_check.sv | 23 ++
 rtl/rv_instr_encoder.sv | 79 +++++++
 tb/tb_rv_instr_encoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - RV32I instruction format, opcode and field-packing definitions
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // Fields a format does not use stay zero; fmt 6/7 carry only the opcode.
    function automatic logic [31:0] pack_instr(input fields_t f);
        logic [31:0] w;
        w = {25'b0, f.opcode};
        case (f.fmt)
            FMT_R: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I: w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:1], f.imm[11], f.opcode};
            FMT_U: w = {f.imm[31:12], f.rd, f.opcode};
            FMT_J: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            default: w = {25'b0, f.opcode};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rv_imm_check.sv
// rtl/rv_imm_check.sv - immediate range/alignment and format validity check
module rv_imm_check
    import rv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        err
);

    // A sign-extended field is representable when all bits above it match its sign bit.
    always_comb begin
        err = 1'b0;
        case (fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_U:        err = |imm[11:0];
            FMT_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - two-stage valid/ready RV32I field packer with IMEM word address
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int                 ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    logic    s1_v;
    logic    s1_err;
    fields_t s1_f;
    fields_t in_f;
    logic    chk_err;
    logic    s1_adv;
    logic    s2_adv;

    assign in_f = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, funct3: in_funct3,
                    rs1: in_rs1, rs2: in_rs2, funct7: in_funct7, imm: in_imm};

    rv_imm_check u_imm_check (
        .fmt (in_fmt),
        .imm (in_imm),
        .err (chk_err)
    );

    // Stage 2 is the output register itself, so it frees up whenever the consumer takes it.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_err    <= 1'b0;
            s1_f      <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
        end else begin
            if (s1_adv) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_f   <= in_f;
                    s1_err <= chk_err;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_v;
                if (s1_v) begin
                    out_instr <= pack_instr(s1_f);
                    out_err   <= s1_err;
                end
            end
            if (out_valid && out_ready) begin
                out_addr <= out_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb/tb_rv_instr_encoder.sv - directed table-driven bench for rv_instr_encoder
module tb_rv_instr_encoder;
    import rv_pkg::*;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    localparam int NV = 19;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;

    int   total = 0;
    int   bad = 0;
    int   exp_addr = 0;
    exp_t q[$];
    int   a2_seen[$];
    vec_t vecs[NV];

    rv_instr_encoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err)
    );

    rv_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_addr(out_addr2), .out_err(out_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: observe transfers at the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            exp_addr = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_word", out_instr, 32'hxxxxxxxx);
                end else begin
                    e = q.pop_front();
                    check("instr", out_instr, e.instr);
                    check("err", {31'b0, out_err}, {31'b0, e.err});
                    check("addr", {22'b0, out_addr}, 32'(exp_addr));
                    exp_addr = (exp_addr + 1) % 1024;
                end
            end
            if (out_valid2 && out_ready2) a2_seen.push_back(int'(out_addr2));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_funct3 = v.f3;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    task automatic send(input vec_t v, input bit must_accept);
        int n;
        n = 0;
        drive(v);
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            step();
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            if (must_accept) check("no_bubble", 32'(n), 32'd0);
            q.push_back('{v.exp_instr, v.exp_err});
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        //                fmt    op     rd     f3    rs1    rs2    f7     imm            instr          err
        vecs[0]  = '{FMT_I, OP_IMM,    5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'd5,         32'h00500093, 1'b0};
        vecs[1]  = '{FMT_S, OP_STORE,  5'd31, 3'd2, 5'd1,  5'd2,  7'h7F, 32'd8,         32'h0020A423, 1'b0};
        vecs[2]  = '{FMT_B, OP_BRANCH, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFFFFFC,  32'hFE000EE3, 1'b0};
        vecs[3]  = '{FMT_U, OP_LUI,    5'd5,  3'd7, 5'd31, 5'd31, 7'h7F, 32'h12345000,  32'h123452B7, 1'b0};
        vecs[4]  = '{FMT_J, OP_JAL,    5'd1,  3'd7, 5'd31, 5'd31, 7'h7F, 32'd2048,      32'h001000EF, 1'b0};
        vecs[5]  = '{FMT_R, OP_REG,    5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'hFFFFFFFF,  32'h002081B3, 1'b0};
        vecs[6]  = '{FMT_R, OP_REG,    5'd3,  3'd0, 5'd1,  5'd2,  7'h20, 32'h0,         32'h402081B3, 1'b0};
        vecs[7]  = '{FMT_I, OP_IMM,    5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'd2048,      32'h80000093, 1'b1};
        vecs[8]  = '{FMT_B, OP_BRANCH, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'd3,         32'h00000163, 1'b1};
        vecs[9]  = '{3'd7,  OP_IMM,    5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'd5,         32'h00000013, 1'b1};
        vecs[10] = '{3'd6,  OP_REG,    5'd3,  3'd1, 5'd1,  5'd2,  7'h20, 32'd0,         32'h00000033, 1'b1};
        vecs[11] = '{FMT_U, OP_LUI,    5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00001001,  32'h00001037, 1'b1};
        vecs[12] = '{FMT_S, OP_STORE,  5'd0,  3'd2, 5'd0,  5'd0,  7'h00, 32'hFFFFFFFF,  32'hFE002FA3, 1'b0};
        vecs[13] = '{FMT_J, OP_JAL,    5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00100000,  32'h8000006F, 1'b1};
        vecs[14] = '{FMT_J, OP_JAL,    5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'd1,         32'h0000006F, 1'b1};
        vecs[15] = '{FMT_I, OP_IMM,    5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFFF800,  32'h80000093, 1'b0};
        vecs[16] = '{FMT_I, OP_IMM,    5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'd2047,      32'h7FF00093, 1'b0};
        vecs[17] = '{FMT_B, OP_BRANCH, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'd4094,      32'h7E000FE3, 1'b0};
        vecs[18] = '{FMT_B, OP_BRANCH, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'd4096,      32'h80000063, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        out_ready2 = 1'b1;
        drive(vecs[0]);
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_out_addr", {22'b0, out_addr}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Two-clock latency from accept to out_valid.
        send(vecs[0], 1'b1);
        check("lat_valid_1clk", {31'b0, out_valid}, 32'd0);
        step();
        check("lat_valid_2clk", {31'b0, out_valid}, 32'd1);
        drain();

        // Whole table back-to-back at full throughput.
        for (int i = 1; i < NV; i++) send(vecs[i], 1'b1);
        drain();

        // Backpressure: two words fill the pipe, third is refused until release.
        out_ready = 1'b0;
        send(vecs[0], 1'b1);
        send(vecs[1], 1'b1);
        drive(vecs[2]);
        in_valid = 1'b1;
        #1;
        check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_instr", out_instr, vecs[0].exp_instr);
            check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        send(vecs[2], 1'b1);
        drain();

        // Reset with both stages full discards them and restarts addressing.
        out_ready = 1'b0;
        send(vecs[3], 1'b1);
        send(vecs[4], 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_addr", {22'b0, out_addr}, 32'd0);
        out_ready = 1'b1;
        send(vecs[5], 1'b1);
        drain();

        // Narrow counter wraps 3 -> 0.
        drive(vecs[0]);
        in_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("w2_in_ready", {31'b0, in_ready2}, 32'd1);
            step();
        end
        in_valid2 = 1'b0;
        for (int i = 0; i < 10 && a2_seen.size() < 5; i++) step();
        check("w2_count", 32'(a2_seen.size()), 32'd5);
        for (int i = 0; i < 5 && i < a2_seen.size(); i++)
            check("w2_addr", 32'(a2_seen[i]), 32'(i % 4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
